// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, decode constants and hit vector for the 68000 bus front end
package bus_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ACK   = 3'd2,
        DRAM  = 3'd3,
        FAULT = 3'd4
    } state_t;
    localparam logic [2:0] FC_IACK = 3'b111;
    localparam int ROM_W = 4;
    localparam int IO_W  = 8;
    typedef struct packed {
        logic iack;
        logic rom;
        logic io;
        logic dram;
        logic bad;
    } hit_t;
endpackage

// File: rtl/bus_decode.sv
// bus_decode: combinational address/function-code decode into a hit vector and active-low chip selects
module bus_decode
    import bus_pkg::*;
#(
    parameter logic [ROM_W-1:0] ROM_BASE = 4'hF,
    parameter logic [IO_W-1:0]  IO_BASE  = 8'hFF
) (
    input  logic [23:16] addr,
    input  logic [2:0]   fc,
    input  logic         rw,
    input  logic         strobe,
    input  logic         overlay,
    output hit_t         hit,
    output logic         cs_dram,
    output logic         cs_rom,
    output logic         cs_io
);
    logic sel, rom_win, io_win, low_win, rom_any;
    always_comb begin
        sel      = ~strobe & (fc != FC_IACK);
        rom_win  = addr[23 -: ROM_W] == ROM_BASE;
        io_win   = addr[23 -: IO_W] == IO_BASE;
        low_win  = addr[23 -: ROM_W] == '0;
        // the I/O window sits inside the ROM window and takes priority
        rom_any  = ~io_win & (rom_win | (overlay & low_win));
        hit.iack = ~strobe & (fc == FC_IACK);
        hit.io   = sel & io_win;
        hit.rom  = sel & rom_any & rw;
        hit.dram = sel & ~overlay & ~rom_win;
        hit.bad  = sel & ~hit.io & ~hit.rom & ~hit.dram;
        cs_dram  = ~hit.dram;
        cs_rom   = ~hit.rom;
        cs_io    = ~hit.io;
    end
endmodule

// File: rtl/bus_controller.sv
// bus_controller: 68000 bus front end -- chip selects, wait-state DTACK, DRAM DTACK merge, BERR timeout, VPA
module bus_controller
    import bus_pkg::*;
#(
    parameter logic [ROM_W-1:0] ROM_BASE     = 4'hF,
    parameter logic [IO_W-1:0]  IO_BASE      = 8'hFF,
    parameter logic [2:0]       ROM_WAIT     = 3'd2,
    parameter logic [2:0]       IO_WAIT      = 3'd4,
    parameter logic [7:0]       BERR_TIMEOUT = 8'd255,
    parameter logic [2:0]       BOOT_READS   = 3'd4
) (
    input  logic        CLK_ALT,
    input  logic        RST,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    input  logic [2:0]  FC,
    input  logic [23:1] ADDR_IN,
    input  logic        DTACK_DRAM,
    output logic        CS_DRAM,
    output logic        CS_ROM,
    output logic        CS_IO,
    output logic        DTACK,
    output logic        BERR,
    output logic        VPA
);
    state_t     state, state_n;
    hit_t       hit;
    logic [2:0] wcnt, wcnt_n, boot, boot_n;
    logic [7:0] tcnt, tcnt_n;
    logic       as1, as1_d, dram_ack, ack_n, overlay;
    logic       dtack_q, berr_q, vpa_q, dtack_n, berr_n, vpa_n;
    logic       unused;

    assign unused  = ^{UDS, LDS, ADDR_IN[15:1]};
    assign overlay = boot < BOOT_READS;

    bus_decode #(.ROM_BASE(ROM_BASE), .IO_BASE(IO_BASE)) u_decode (
        .addr(ADDR_IN[23:16]), .fc(FC), .rw(RW), .strobe(AS), .overlay(overlay),
        .hit(hit), .cs_dram(CS_DRAM), .cs_rom(CS_ROM), .cs_io(CS_IO)
    );

    always_ff @(posedge CLK_ALT) begin
        if (!RST) begin
            state    <= IDLE;
            wcnt     <= '0;
            tcnt     <= '0;
            boot     <= '0;
            as1      <= 1'b1;
            as1_d    <= 1'b1;
            dram_ack <= 1'b0;
            dtack_q  <= 1'b1;
            berr_q   <= 1'b1;
            vpa_q    <= 1'b1;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            tcnt     <= tcnt_n;
            boot     <= boot_n;
            as1      <= AS;
            as1_d    <= as1;
            dram_ack <= ack_n;
            dtack_q  <= dtack_n;
            berr_q   <= berr_n;
            vpa_q    <= vpa_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        tcnt_n  = (~as1 & (state == WAIT | state == DRAM) & tcnt != 8'hFF) ? tcnt + 8'd1 : tcnt;
        ack_n   = dram_ack;
        boot_n  = boot + {2'b0, as1 & ~as1_d & overlay};
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        vpa_n   = 1'b1;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                ack_n  = 1'b0;
                if (~as1 & ~AS) begin
                    if (hit.iack) begin
                        state_n = ACK;
                        vpa_n   = 1'b0;
                    end else if (hit.rom) begin
                        state_n = WAIT;
                        wcnt_n  = ROM_WAIT - 3'd1;
                    end else if (hit.io) begin
                        state_n = WAIT;
                        wcnt_n  = IO_WAIT - 3'd1;
                    end else if (hit.dram) begin
                        state_n = DRAM;
                    end else if (hit.bad) begin
                        state_n = FAULT;
                        berr_n  = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (as1) state_n = IDLE;
                else if (wcnt == '0) begin
                    state_n = ACK;
                    dtack_n = 1'b0;
                end else wcnt_n = wcnt - 3'd1;
            end
            ACK: begin
                if (as1) state_n = IDLE;
                else begin
                    dtack_n = dtack_q;
                    vpa_n   = vpa_q;
                end
            end
            DRAM: begin
                // an acknowledge arriving on the expiry edge itself still loses to the timeout
                if (as1) state_n = IDLE;
                else if (tcnt == BERR_TIMEOUT & ~dram_ack) begin
                    state_n = FAULT;
                    berr_n  = 1'b0;
                end else if (~DTACK_DRAM) ack_n = 1'b1;
            end
            FAULT: begin
                if (as1) state_n = IDLE;
                else berr_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign DTACK = dtack_q & (DTACK_DRAM | state != DRAM);
    assign BERR  = berr_q;
    assign VPA   = vpa_q;
endmodule
